// File: rtl/pal_pkg.sv
// Shared definitions for the gal_pld registered logic array: chain layout helpers and load-FSM states.
// Optional AND-plane feedback of macrocell registers is compiled in with PAL_FEEDBACK_EN.
package pal_pkg;

`ifdef PAL_FEEDBACK_EN
    localparam bit FB_EN = 1'b1;
`else
    localparam bit FB_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        EMPTY,
        LOADING,
        FULL
    } loadState_e;

    function automatic int num_vars(input int n, input int m, input bit fb);
        return fb ? (n + m) : n;
    endfunction

    function automatic int sr_len(input int n, input int m, input int p, input bit fb);
        int ni;
        ni = num_vars(n, m, fb);
        return 2 * ni * p + p * m + 2 * m;
    endfunction

    function automatic int and_idx(input int p, input int c, input int np);
        return p + c * np;
    endfunction

    function automatic int or_idx(input int p, input int m, input int ni, input int np);
        return 2 * ni * np + p + m * np;
    endfunction

    // Macrocell bits sit after both planes, two bits (REG, INV) per output.
    function automatic int mc_reg_idx(input int m, input int ni, input int np, input int nm);
        return 2 * ni * np + np * nm + 2 * m;
    endfunction

    function automatic int mc_inv_idx(input int m, input int ni, input int np, input int nm);
        return 2 * ni * np + np * nm + 2 * m + 1;
    endfunction

endpackage

// File: rtl/gal_pld_if.sv
// Configuration and data bus of gal_pld; the array sits on the slave side.
interface gal_pld_if #(
    parameter int N = 8,
    parameter int M = 8
);
    logic         EN;
    logic         CFG_EN;
    logic         CFG_DATA;
    logic         CFG_COMMIT;
    logic         CFG_DONE;
    logic         CFG_ERR;
    logic [N-1:0] INPUT_VARS;
    logic [M-1:0] OUTPUT_VALS;

    modport master (
        output EN, CFG_EN, CFG_DATA, CFG_COMMIT, INPUT_VARS,
        input  CFG_DONE, CFG_ERR, OUTPUT_VALS
    );

    modport slave (
        input  EN, CFG_EN, CFG_DATA, CFG_COMMIT, INPUT_VARS,
        output CFG_DONE, CFG_ERR, OUTPUT_VALS
    );
endinterface

// File: rtl/pal_macrocell.sv
// One output macrocell: polarity control, optional register, commit-clear.
// The Q port only exists when PAL_FEEDBACK_EN routes it back into the AND plane.
module pal_macrocell (
    input  logic clk,
    input  logic rst,
    input  logic sum_i,
    input  logic reg_i,
    input  logic inv_i,
    input  logic en_i,
    input  logic clr_i,
    output logic out_o
`ifdef PAL_FEEDBACK_EN
    ,
    output logic q_o
`endif
);

    logic s;
    logic q_q;
    logic q_d;

    assign s = sum_i ^ inv_i;

    // The register tracks S even when the cell is combinational, so switching
    // the REG bit never exposes a stale value; a commit-clear beats the enable.
    always_comb begin
        q_d = q_q;
        if (clr_i) begin
            q_d = 1'b0;
        end else if (en_i) begin
            q_d = s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign out_o = reg_i ? q_q : s;

`ifdef PAL_FEEDBACK_EN
    assign q_o = q_q;
`endif

endmodule

// File: rtl/gal_pld.sv
// Reprogrammable AND/OR array with per-output macrocells and a serially loaded shadow configuration.
// Define PAL_FEEDBACK_EN to add macrocell Q/~Q as extra AND-plane columns.
module gal_pld
    import pal_pkg::*;
#(
    parameter int N = 8,
    parameter int M = 8,
    parameter int P = 8
) (
    input logic      CLK,
    input logic      RES,
    gal_pld_if.slave bus
);

    localparam int NI     = num_vars(N, M, FB_EN);
    localparam int SR_LEN = sr_len(N, M, P, FB_EN);
    localparam int CW     = $clog2(SR_LEN + 1);
    localparam logic [CW-1:0] SR_LEN_C = CW'(SR_LEN);
    localparam logic [CW-1:0] ONE_C    = CW'(1);

    loadState_e        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [SR_LEN-1:0] shadow_q, shadow_d;
    logic [SR_LEN-1:0] active_q, active_d;
    logic              err_q, err_d;
    logic              commit;

    logic [NI-1:0]     vars;
    logic [2*NI-1:0]   cols;
    logic [P-1:0]      pterm;
    logic [M-1:0]      sum;
    logic [M-1:0]      outVals;

`ifdef PAL_FEEDBACK_EN
    logic [M-1:0] qVec;
    assign vars = {qVec, bus.INPUT_VARS};
`else
    assign vars = bus.INPUT_VARS;
`endif

    // Shadow/active registers and load bookkeeping; the array itself only reads active_q.
    always_ff @(posedge CLK) begin
        if (RES) begin
            state_q  <= EMPTY;
            cnt_q    <= '0;
            shadow_q <= '0;
            active_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            err_q    <= err_d;
        end
    end

    // A commit in FULL copies the pre-shift shadow, so a simultaneous shift
    // starts the next image at count one instead of zero.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        active_d = active_q;
        err_d    = 1'b0;
        commit   = 1'b0;

        if (bus.CFG_EN) begin
            shadow_d = {bus.CFG_DATA, shadow_q[SR_LEN-1:1]};
        end

        case (state_q)
            EMPTY: begin
                err_d = bus.CFG_COMMIT;
                if (bus.CFG_EN) begin
                    cnt_d   = ONE_C;
                    state_d = LOADING;
                end
            end
            LOADING: begin
                err_d = bus.CFG_COMMIT;
                if (bus.CFG_EN) begin
                    cnt_d = cnt_q + ONE_C;
                    if (cnt_q + ONE_C == SR_LEN_C) begin
                        state_d = FULL;
                    end
                end
            end
            FULL: begin
                if (bus.CFG_COMMIT) begin
                    commit   = 1'b1;
                    active_d = shadow_q;
                    if (bus.CFG_EN) begin
                        cnt_d   = ONE_C;
                        state_d = LOADING;
                    end else begin
                        cnt_d   = '0;
                        state_d = EMPTY;
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = EMPTY;
            end
        endcase
    end

    for (genvar v = 0; v < NI; v++) begin : g_cols
        assign cols[2*v]   = vars[v];
        assign cols[2*v+1] = ~vars[v];
    end

    // Unselected columns are forced true; a term with no selected column is 0.
    for (genvar p = 0; p < P; p++) begin : g_pt
        logic [2*NI-1:0] andMask;
        for (genvar c = 0; c < 2*NI; c++) begin : g_col
            assign andMask[c] = active_q[and_idx(p, c, P)];
        end
        assign pterm[p] = (|andMask) & (&(cols | ~andMask));
    end

    for (genvar m = 0; m < M; m++) begin : g_mc
        logic [P-1:0] orMask;
        for (genvar p = 0; p < P; p++) begin : g_or
            assign orMask[p] = active_q[or_idx(p, m, NI, P)];
        end
        assign sum[m] = |(pterm & orMask);

        pal_macrocell u_mc (
            .clk   (CLK),
            .rst   (RES),
            .sum_i (sum[m]),
            .reg_i (active_q[mc_reg_idx(m, NI, P, M)]),
            .inv_i (active_q[mc_inv_idx(m, NI, P, M)]),
            .en_i  (bus.EN),
            .clr_i (commit),
            .out_o (outVals[m])
`ifdef PAL_FEEDBACK_EN
            ,
            .q_o   (qVec[m])
`endif
        );
    end

    assign bus.OUTPUT_VALS = outVals;
    assign bus.CFG_DONE    = (state_q == FULL);
    assign bus.CFG_ERR     = err_q;

endmodule

// File: tb/tb_gal_pld.sv
// Self-checking bench for gal_pld: directed scenarios plus randomized configs against a behavioural model.
// Exercises the feedback scenario when compiled with PAL_FEEDBACK_EN.
module tb_gal_pld;

    localparam int N = 4;
    localparam int M = 2;
    localparam int P = 4;
`ifdef PAL_FEEDBACK_EN
    localparam int NI = N + M;
`else
    localparam int NI = N;
`endif
    localparam int SR_LEN  = 2 * NI * P + P * M + 2 * M;
    localparam int OR_BASE = 2 * NI * P;
    localparam int MC_BASE = OR_BASE + P * M;

    logic clk = 1'b0;
    logic res;

    always #5 clk = ~clk;

    gal_pld_if #(.N(N), .M(M)) bus ();

    gal_pld #(.N(N), .M(M), .P(P)) dut (
        .CLK (clk),
        .RES (res),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Model state: shadow as a sliding window of the last SR_LEN bits, oldest first.
    bit          mShadow[$];
    bit          mActive[SR_LEN];
    bit [M-1:0]  mQ;
    int          mLoaded;
    bit          mErr;
    bit          img[SR_LEN];

    function automatic bit sumOf(input int m, input bit [N-1:0] inVars);
        bit result = 1'b0;
        for (int p = 0; p < P; p++) begin
            bit used = 1'b0;
            bit hit  = 1'b1;
            if (!mActive[OR_BASE + p + m * P]) continue;
            for (int v = 0; v < NI; v++) begin
                bit val = (v < N) ? inVars[v] : mQ[v - N];
                if (mActive[p + (2 * v) * P]) begin
                    used = 1'b1;
                    if (!val) hit = 1'b0;
                end
                if (mActive[p + (2 * v + 1) * P]) begin
                    used = 1'b1;
                    if (val) hit = 1'b0;
                end
            end
            if (used && hit) result = 1'b1;
        end
        return result;
    endfunction

    function automatic bit [M-1:0] modelS(input bit [N-1:0] inVars);
        bit [M-1:0] s;
        for (int m = 0; m < M; m++) s[m] = sumOf(m, inVars) ^ mActive[MC_BASE + 2 * m + 1];
        return s;
    endfunction

    function automatic bit [M-1:0] modelOut(input bit [N-1:0] inVars);
        bit [M-1:0] s = modelS(inVars);
        bit [M-1:0] o;
        for (int m = 0; m < M; m++) o[m] = mActive[MC_BASE + 2 * m] ? mQ[m] : s[m];
        return o;
    endfunction

    task automatic modelReset();
        mShadow.delete();
        repeat (SR_LEN) mShadow.push_back(1'b0);
        foreach (mActive[i]) mActive[i] = 1'b0;
        mQ      = '0;
        mLoaded = 0;
        mErr    = 1'b0;
    endtask

    task automatic clearImg();
        foreach (img[i]) img[i] = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".out"},  32'(bus.OUTPUT_VALS), 32'(modelOut(bus.INPUT_VARS)));
        checkOutput({tag, ".done"}, 32'(bus.CFG_DONE),    32'(mLoaded >= SR_LEN));
        checkOutput({tag, ".err"},  32'(bus.CFG_ERR),     32'(mErr));
    endtask

    // One clock cycle: drive, check the combinational path, clock, update model, check again.
    task automatic applyStimulus(input bit [N-1:0] inVars, input bit en, input bit cfgEn,
                                 input bit data, input bit commit);
        bit [M-1:0] s;
        bit         full;
        bus.INPUT_VARS = inVars;
        bus.EN         = en;
        bus.CFG_EN     = cfgEn;
        bus.CFG_DATA   = data;
        bus.CFG_COMMIT = commit;
        #1;
        checkAll("pre");
        s    = modelS(inVars);
        full = (mLoaded >= SR_LEN);
        @(posedge clk);
        mErr = commit && !full;
        if (commit && full) begin
            for (int i = 0; i < SR_LEN; i++) mActive[i] = mShadow[i];
            mQ = '0;
        end else if (en) begin
            mQ = s;
        end
        if (cfgEn) begin
            mShadow.push_back(data);
            void'(mShadow.pop_front());
        end
        if (commit && full) mLoaded = cfgEn ? 1 : 0;
        else if (cfgEn) mLoaded = (mLoaded + 1 > SR_LEN) ? SR_LEN : mLoaded + 1;
        #1;
        checkAll("post");
    endtask

    task automatic applyReset();
        res            = 1'b1;
        bus.EN         = 1'b0;
        bus.CFG_EN     = 1'b0;
        bus.CFG_DATA   = 1'b0;
        bus.CFG_COMMIT = 1'b0;
        @(posedge clk);
        modelReset();
        #1;
        res = 1'b0;
    endtask

    task automatic loadImage(input bit en, input bit randIn);
        for (int i = 0; i < SR_LEN; i++) begin
            applyStimulus(randIn ? N'($urandom) : '0, en, 1'b1, img[i], 1'b0);
        end
    endtask

    initial begin
        $display("[TB] gal_pld bench, SR_LEN=%0d", SR_LEN);
        bus.INPUT_VARS = '0;
        res            = 1'b1;
        bus.EN         = 1'b0;
        bus.CFG_EN     = 1'b0;
        bus.CFG_DATA   = 1'b0;
        bus.CFG_COMMIT = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        res = 1'b0;

        // Reset state
        checkOutput("rst.out",  32'(bus.OUTPUT_VALS), 32'd0);
        checkOutput("rst.done", 32'(bus.CFG_DONE),    32'd0);
        checkOutput("rst.err",  32'(bus.CFG_ERR),     32'd0);

        // OUT0 = IN0 & ~IN1 combinational; OUT1 = ~IN2 registered
        clearImg();
        img[0 + 0 * P]         = 1'b1;
        img[0 + 3 * P]         = 1'b1;
        img[OR_BASE + 0]       = 1'b1;
        img[1 + 4 * P]         = 1'b1;
        img[OR_BASE + 1 + P]   = 1'b1;
        img[MC_BASE + 2]       = 1'b1;
        img[MC_BASE + 3]       = 1'b1;
        loadImage(1'b0, 1'b0);
        checkOutput("load.done", 32'(bus.CFG_DONE), 32'd1);
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("commit.done", 32'(bus.CFG_DONE), 32'd0);
        bus.INPUT_VARS = 4'b0001;
        #1;
        checkOutput("and.0001", 32'(bus.OUTPUT_VALS[0]), 32'd1);
        bus.INPUT_VARS = 4'b0011;
        #1;
        checkOutput("and.0011", 32'(bus.OUTPUT_VALS[0]), 32'd0);

        applyStimulus(4'b0100, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("reg.in2hi", 32'(bus.OUTPUT_VALS[1]), 32'd0);
        applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("reg.in2lo", 32'(bus.OUTPUT_VALS[1]), 32'd1);
        for (int k = 0; k < 3; k++) begin
            applyStimulus((k % 2 == 0) ? 4'b0100 : 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
            checkOutput("reg.hold", 32'(bus.OUTPUT_VALS[1]), 32'd1);
        end

        // Short load then illegal commit
        for (int i = 0; i < SR_LEN - 1; i++) applyStimulus(4'b0001, 1'b0, 1'b1, 1'($urandom), 1'b0);
        applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("short.err",  32'(bus.CFG_ERR),        32'd1);
        checkOutput("short.done", 32'(bus.CFG_DONE),       32'd0);
        checkOutput("short.out0", 32'(bus.OUTPUT_VALS[0]), 32'd1);
        applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("short.errpulse", 32'(bus.CFG_ERR), 32'd0);
        applyStimulus(4'b0001, 1'b0, 1'b1, 1'($urandom), 1'b0);
        checkOutput("last.done", 32'(bus.CFG_DONE), 32'd1);

        // Reset mid-load
        applyReset();
        for (int i = 0; i < 20; i++) applyStimulus(N'($urandom), 1'b1, 1'b1, 1'($urandom), 1'b0);
        applyReset();
        checkOutput("midrst.out",  32'(bus.OUTPUT_VALS), 32'd0);
        checkOutput("midrst.done", 32'(bus.CFG_DONE),    32'd0);
        applyStimulus(4'b1111, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("midrst.err", 32'(bus.CFG_ERR), 32'd1);

`ifdef PAL_FEEDBACK_EN
        // Toggle flop through ~Q0 feedback
        clearImg();
        img[0 + 9 * P]   = 1'b1;
        img[OR_BASE + 0] = 1'b1;
        img[MC_BASE + 0] = 1'b1;
        loadImage(1'b0, 1'b0);
        applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("fb.commit", 32'(bus.OUTPUT_VALS[0]), 32'd0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
            checkOutput("fb.toggle", 32'(bus.OUTPUT_VALS[0]), 32'((k + 1) % 2));
        end
        loadImage(1'b1, 1'b0);
        applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("fb.clear", 32'(bus.OUTPUT_VALS[0]), 32'd0);
`endif

        // Random configurations with random traffic, including overlapping loads and commits
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < SR_LEN; i++) begin
                img[i] = (i < OR_BASE) ? ($urandom_range(0, 3) == 0) : 1'($urandom);
            end
            loadImage(1'($urandom), 1'b1);
            applyStimulus(N'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b1);
            for (int k = 0; k < 30; k++) begin
                applyStimulus(N'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
                              1'($urandom), ($urandom_range(0, 11) == 0));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
